// File: rtl/nav_pkg.sv
// -----------------------------------------------------------------------------
// nav_pkg
// Shared types and helpers for the navigation sensor front end.
//   ir_chan_t      : ADC mux select for the three IR range sensors
//   sched_state_t  : IR ADC scheduler FSM states
//   IR_W           : width of one IR reading / ADC word
//   next_chan()    : round-robin successor within a frame (RIGHT->FORWARD->LEFT)
//   fwd_flag_next(): hysteretic forward-wall decision
// -----------------------------------------------------------------------------
package nav_pkg;

    localparam int IR_W = 16;

    typedef enum logic [1:0] {
        IR_RIGHT   = 2'd0,
        IR_FORWARD = 2'd1,
        IR_LEFT    = 2'd2
    } ir_chan_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        START     = 3'd2,
        WAIT_EOC  = 3'd3,
        PUBLISH   = 3'd4
    } sched_state_t;

    // LEFT is the last channel of a frame; callers handle the wrap themselves.
    function automatic ir_chan_t next_chan(input ir_chan_t chan);
        ir_chan_t nxt;
        case (chan)
            IR_RIGHT:   nxt = IR_FORWARD;
            IR_FORWARD: nxt = IR_LEFT;
            default:    nxt = IR_RIGHT;
        endcase
        return nxt;
    endfunction

    // Strictly above hi sets, strictly below lo clears, the band in between holds.
    function automatic logic fwd_flag_next(input logic [IR_W-1:0] avg,
                                           input logic [IR_W-1:0] hi,
                                           input logic [IR_W-1:0] lo,
                                           input logic            cur);
        logic flag;
        if (avg > hi) begin
            flag = 1'b1;
        end else if (avg < lo) begin
            flag = 1'b0;
        end else begin
            flag = cur;
        end
        return flag;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Fixed-rate tick generator: while en_in is high a free-running counter emits a
// one-cycle tick_out every FRAME_CYCLES clocks. While en_in is low the counter
// is held at 0, so the first tick comes FRAME_CYCLES cycles after enabling.
// Ports:
//   clk_in   in  1  clock
//   reset_in in  1  asynchronous, active-high reset
//   en_in    in  1  run enable
//   tick_out out 1  registered one-cycle tick
// -----------------------------------------------------------------------------
module frame_tick_gen #(
    parameter int FRAME_CYCLES = 100_000
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic en_in,
    output logic tick_out
);

    localparam int               CNT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Frame counter and registered tick.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (!en_in) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick_out = r_tick;

endmodule

// File: rtl/ir_adc_scheduler.sv
// -----------------------------------------------------------------------------
// ir_adc_scheduler
// Time-shares one ADC between the right, forward and left IR range sensors.
// Each frame (started by frame_tick_gen) converts every channel 2^AVG_LOG2
// times, publishes the truncated average, and derives a hysteretic
// forward-wall flag from the forward average.
// Ports:
//   clk_in, reset_in        clock, asynchronous active-high reset
//   enable_in               run frames while high; low aborts to IDLE
//   err_clear_in            clears sticky error flags (a same-cycle error wins)
//   adc_busy_in             ADC busy, start is stalled while high
//   adc_start_out           one-cycle conversion start pulse
//   adc_channel_out[1:0]    mux select, stable through a conversion
//   adc_eoc_in              end of conversion, adc_data_in valid
//   adc_data_in[15:0]       unsigned left-justified result
//   right/forward/left_ir_out[15:0]  averaged readings
//   forward_wall_out        hysteretic forward-obstacle flag
//   frame_valid_out         pulse the cycle after left_ir_out updates
//   timeout_err_out         sticky conversion timeout
//   overrun_err_out         sticky frame tick while a frame was running
// -----------------------------------------------------------------------------
module ir_adc_scheduler
    import nav_pkg::*;
#(
    parameter int          FRAME_CYCLES   = 100_000,
    parameter int          AVG_LOG2       = 2,
    parameter int          TIMEOUT_CYCLES = 1_000,
    parameter logic [15:0] FWD_HI         = 16'h6000,
    parameter logic [15:0] FWD_LO         = 16'h5000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        enable_in,
    input  logic        err_clear_in,
    input  logic        adc_busy_in,
    output logic        adc_start_out,
    output logic [1:0]  adc_channel_out,
    input  logic        adc_eoc_in,
    input  logic [15:0] adc_data_in,
    output logic [15:0] right_ir_out,
    output logic [15:0] forward_ir_out,
    output logic [15:0] left_ir_out,
    output logic        forward_wall_out,
    output logic        frame_valid_out,
    output logic        timeout_err_out,
    output logic        overrun_err_out
);

    localparam int               ACC_W    = IR_W + AVG_LOG2;
    localparam int               SMP_W    = AVG_LOG2 + 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
    localparam int               TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    sched_state_t      r_state;
    ir_chan_t          r_chan;
    logic [ACC_W-1:0]  r_acc;
    logic [SMP_W-1:0]  r_smp_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_start;
    logic [IR_W-1:0]   r_right;
    logic [IR_W-1:0]   r_fwd;
    logic [IR_W-1:0]   r_left;
    logic              r_wall;
    logic              r_frame_done;
    logic              r_frame_valid;
    logic              r_timeout_err;
    logic              r_overrun_err;

    sched_state_t      w_state_nxt;
    ir_chan_t          w_chan_nxt;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic [SMP_W-1:0]  w_smp_nxt;
    logic [TO_W-1:0]   w_to_nxt;
    logic              w_start_nxt;
    logic              w_publish;
    logic              w_frame_done;
    logic              w_timeout;
    logic              w_overrun;
    logic              w_tick;
    logic [IR_W-1:0]   w_avg;

    frame_tick_gen #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_tick (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .en_in    (enable_in),
        .tick_out (w_tick)
    );

    // Truncating average of the completed accumulation.
    assign w_avg = IR_W'(r_acc >> AVG_LOG2);

    // A tick that the FSM cannot accept is dropped and flagged.
    assign w_overrun = w_tick & enable_in & (r_state != WAIT_TICK);

    // FSM state register.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control; enable_in low overrides every state.
    always_comb begin
        w_state_nxt  = r_state;
        w_chan_nxt   = r_chan;
        w_acc_nxt    = r_acc;
        w_smp_nxt    = r_smp_cnt;
        w_to_nxt     = r_to_cnt;
        w_start_nxt  = 1'b0;
        w_publish    = 1'b0;
        w_frame_done = 1'b0;
        w_timeout    = 1'b0;
        if (!enable_in) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_smp_nxt   = '0;
            w_to_nxt    = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (w_tick) begin
                        w_state_nxt = START;
                        w_chan_nxt  = IR_RIGHT;
                    end else begin
                        w_state_nxt = WAIT_TICK;
                    end
                end
                START: begin
                    if (!adc_busy_in) begin
                        w_start_nxt = 1'b1;
                        w_to_nxt    = '0;
                        w_state_nxt = WAIT_EOC;
                    end else begin
                        w_state_nxt = START;
                    end
                end
                WAIT_EOC: begin
                    if (adc_eoc_in) begin
                        w_acc_nxt = r_acc + ACC_W'(adc_data_in);
                        w_smp_nxt = r_smp_cnt + SMP_W'(1);
                        if (r_smp_cnt == SMP_LAST) begin
                            w_state_nxt = PUBLISH;
                        end else begin
                            w_state_nxt = START;
                        end
                    end else if (r_to_cnt == TO_LIMIT) begin
                        // Give up on this channel: its partial sum is dropped
                        // and its output keeps the previous frame's value.
                        w_timeout = 1'b1;
                        w_acc_nxt = '0;
                        w_smp_nxt = '0;
                        if (r_chan == IR_LEFT) begin
                            w_frame_done = 1'b1;
                            w_state_nxt  = WAIT_TICK;
                        end else begin
                            w_chan_nxt  = next_chan(r_chan);
                            w_state_nxt = START;
                        end
                    end else begin
                        w_to_nxt = r_to_cnt + TO_W'(1);
                    end
                end
                PUBLISH: begin
                    w_publish = 1'b1;
                    w_acc_nxt = '0;
                    w_smp_nxt = '0;
                    if (r_chan == IR_LEFT) begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = WAIT_TICK;
                    end else begin
                        w_chan_nxt  = next_chan(r_chan);
                        w_state_nxt = START;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Datapath registers, published readings and forward-wall flag.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_chan        <= IR_RIGHT;
            r_acc         <= '0;
            r_smp_cnt     <= '0;
            r_to_cnt      <= '0;
            r_start       <= 1'b0;
            r_right       <= '0;
            r_fwd         <= '0;
            r_left        <= '0;
            r_wall        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            r_chan        <= w_chan_nxt;
            r_acc         <= w_acc_nxt;
            r_smp_cnt     <= w_smp_nxt;
            r_to_cnt      <= w_to_nxt;
            r_start       <= w_start_nxt;
            // Extra stage so frame_valid lands the cycle after left_ir updates.
            r_frame_done  <= w_frame_done;
            r_frame_valid <= r_frame_done;
            if (w_publish) begin
                case (r_chan)
                    IR_RIGHT: begin
                        r_right <= w_avg;
                    end
                    IR_FORWARD: begin
                        r_fwd  <= w_avg;
                        r_wall <= fwd_flag_next(w_avg, FWD_HI, FWD_LO, r_wall);
                    end
                    IR_LEFT: begin
                        r_left <= w_avg;
                    end
                    default: begin
                        r_right <= r_right;
                    end
                endcase
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout | (r_timeout_err & ~err_clear_in);
            r_overrun_err <= w_overrun | (r_overrun_err & ~err_clear_in);
        end
    end

    assign adc_start_out    = r_start;
    assign adc_channel_out  = r_chan;
    assign right_ir_out     = r_right;
    assign forward_ir_out   = r_fwd;
    assign left_ir_out      = r_left;
    assign forward_wall_out = r_wall;
    assign frame_valid_out  = r_frame_valid;
    assign timeout_err_out  = r_timeout_err;
    assign overrun_err_out  = r_overrun_err;

endmodule
